// File: rtl/conv_window_builder.sv
// conv_window_builder
//   Converts a raster stream of packed feature pairs into 3x4-feature windows
//   (two adjacent 3x3 windows sharing the centre columns), zero padded at every
//   frame border. Two external RAM line caches supply the previous two rows:
//   cache0 returns the word written one row earlier, cache1 the word written
//   two rows earlier (cache1 is fed from cache0's read port).
//
// Ports
//   system_clk, rst_n          clock, asynchronous active-low reset
//   frame_start                starts a frame in IDLE and latches row_size/col_size
//   row_size, col_size         words per row (3..1023), rows per frame (2..1023)
//   in_valid, in_data, in_ready  input word stream ([FW-1:0] = even pixel)
//   cache_wr_en                write strobe shared by both caches (one per beat)
//   cache_shift_size           row_size-2, programs the cache delay line
//   cache0_wr_data/rd_data     row-1 tap
//   cache1_wr_data/rd_data     row-2 tap
//   window_valid, window_data  window output, feature[r*4+c] at [(r*4+c)*FW +: FW]
//   frame_done                 one-cycle pulse after the last window of a frame
module conv_window_builder #(
    parameter int unsigned FEATURE_WIDTH = 8
) (
    input  logic                        system_clk,
    input  logic                        rst_n,
    input  logic                        frame_start,
    input  logic [9:0]                  row_size,
    input  logic [9:0]                  col_size,
    input  logic                        in_valid,
    input  logic [2*FEATURE_WIDTH-1:0]  in_data,
    output logic                        in_ready,
    output logic                        cache_wr_en,
    output logic [9:0]                  cache_shift_size,
    output logic [2*FEATURE_WIDTH-1:0]  cache0_wr_data,
    input  logic [2*FEATURE_WIDTH-1:0]  cache0_rd_data,
    output logic [2*FEATURE_WIDTH-1:0]  cache1_wr_data,
    input  logic [2*FEATURE_WIDTH-1:0]  cache1_rd_data,
    output logic                        window_valid,
    output logic [12*FEATURE_WIDTH-1:0] window_data,
    output logic                        frame_done
);

    localparam int unsigned FW = FEATURE_WIDTH;
    localparam int unsigned DW = 2 * FEATURE_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [9:0]           r_row_size;
    logic [9:0]           r_col_size;
    logic [9:0]           r_shift;
    logic [9:0]           r_col_in;
    logic [10:0]          r_row_in;
    logic [10:0]          r_flush_cnt;
    logic [9:0]           r_rc;
    logic [9:0]           r_kc;
    logic [DW-1:0]        r_prev [3];
    logic [DW-1:0]        r_cur  [3];
    logic                 r_win_valid;
    logic [12*FW-1:0]     r_win_data;
    logic                 r_done_pend;
    logic                 r_frame_done;

    logic                 w_beat;
    logic                 w_last_in;
    logic                 w_last_flush;
    logic                 w_emit;
    logic [DW-1:0]        w_word;
    logic [DW-1:0]        w_new [3];
    logic [12*FW-1:0]     w_win;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state and beat control ----------------
    always_comb begin
        w_state_nxt  = r_state;
        in_ready     = 1'b0;
        w_beat       = 1'b0;
        w_word       = '0;
        w_last_in    = 1'b0;
        w_last_flush = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                in_ready  = 1'b1;
                w_beat    = in_valid;
                w_word    = in_data;
                w_last_in = in_valid
                          && (r_row_in == {1'b0, r_col_size} - 11'd1)
                          && (r_col_in == r_row_size - 10'd1);
                if (w_last_in) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // row_size+1 zero beats push the last row and the final
                // centre column out of the line caches.
                w_beat       = 1'b1;
                w_last_flush = (r_flush_cnt == {1'b0, r_row_size});
                if (w_last_flush) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A beat completes the window whose centre lies one row and one word
    // behind it, so nothing is emitted for the first row_size+1 beats.
    assign w_emit = w_beat
                 && ((r_row_in >= 11'd2) || ((r_row_in == 11'd1) && (r_col_in != '0)));

    assign w_new[0] = cache1_rd_data;
    assign w_new[1] = cache0_rd_data;
    assign w_new[2] = w_word;

    // ---------------- Window assembly with border padding ----------------
    always_comb begin
        w_win = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            if (!((r == 0 && r_rc == '0) || (r == 2 && r_rc == r_col_size - 10'd1))) begin
                if (r_kc != '0) begin
                    w_win[(r*4+0)*FW +: FW] = r_prev[r][DW-1:FW];
                end
                w_win[(r*4+1)*FW +: FW] = r_cur[r][FW-1:0];
                w_win[(r*4+2)*FW +: FW] = r_cur[r][DW-1:FW];
                if (r_kc != r_row_size - 10'd1) begin
                    w_win[(r*4+3)*FW +: FW] = w_new[r][FW-1:0];
                end
            end
        end
    end

    // ---------------- Datapath and counters ----------------
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_size   <= '0;
            r_col_size   <= '0;
            r_shift      <= '0;
            r_col_in     <= '0;
            r_row_in     <= '0;
            r_flush_cnt  <= '0;
            r_rc         <= '0;
            r_kc         <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                r_prev[i] <= '0;
                r_cur[i]  <= '0;
            end
            r_win_valid  <= 1'b0;
            r_win_data   <= '0;
            r_done_pend  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_win_valid  <= w_emit;
            r_done_pend  <= w_last_flush;
            r_frame_done <= r_done_pend;
            if (w_emit) begin
                r_win_data <= w_win;
            end

            if (r_state == S_IDLE && frame_start) begin
                r_row_size  <= row_size;
                r_col_size  <= col_size;
                r_shift     <= row_size - 10'd2;
                r_col_in    <= '0;
                r_row_in    <= '0;
                r_flush_cnt <= '0;
                r_rc        <= '0;
                r_kc        <= '0;
                for (int unsigned i = 0; i < 3; i++) begin
                    r_prev[i] <= '0;
                    r_cur[i]  <= '0;
                end
            end else if (w_beat) begin
                if (r_col_in == r_row_size - 10'd1) begin
                    r_col_in <= '0;
                    r_row_in <= r_row_in + 11'd1;
                end else begin
                    r_col_in <= r_col_in + 10'd1;
                end
                if (r_state == S_FLUSH) begin
                    r_flush_cnt <= r_flush_cnt + 11'd1;
                end
                for (int unsigned i = 0; i < 3; i++) begin
                    r_prev[i] <= r_cur[i];
                    r_cur[i]  <= w_new[i];
                end
                if (w_emit) begin
                    if (r_kc == r_row_size - 10'd1) begin
                        r_kc <= '0;
                        r_rc <= r_rc + 10'd1;
                    end else begin
                        r_kc <= r_kc + 10'd1;
                    end
                end
            end
        end
    end

    assign cache_wr_en      = w_beat;
    assign cache_shift_size = r_shift;
    assign cache0_wr_data   = w_word;
    assign cache1_wr_data   = cache0_rd_data;
    assign window_valid     = r_win_valid;
    assign window_data      = r_win_data;
    assign frame_done       = r_frame_done;

endmodule

// File: tb/tb_conv_window_builder.sv
// tb_conv_window_builder
//   Randomized bench for conv_window_builder. Line caches are modelled as
//   write-history queues; expected windows come from direct 2-D pixel lookup
//   with out-of-frame positions reading as zero.
module tb_conv_window_builder;

    localparam int unsigned FW = 8;
    localparam int unsigned DW = 2 * FW;
    localparam int unsigned WW = 12 * FW;

    logic           system_clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           frame_start = 1'b0;
    logic [9:0]     row_size = '0;
    logic [9:0]     col_size = '0;
    logic           in_valid = 1'b0;
    logic [DW-1:0]  in_data = '0;
    logic           in_ready;
    logic           cache_wr_en;
    logic [9:0]     cache_shift_size;
    logic [DW-1:0]  cache0_wr_data;
    logic [DW-1:0]  cache0_rd_data = '0;
    logic [DW-1:0]  cache1_wr_data;
    logic [DW-1:0]  cache1_rd_data = '0;
    logic           window_valid;
    logic [WW-1:0]  window_data;
    logic           frame_done;

    conv_window_builder #(.FEATURE_WIDTH(FW)) dut (
        .system_clk       (system_clk),
        .rst_n            (rst_n),
        .frame_start      (frame_start),
        .row_size         (row_size),
        .col_size         (col_size),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .cache_wr_en      (cache_wr_en),
        .cache_shift_size (cache_shift_size),
        .cache0_wr_data   (cache0_wr_data),
        .cache0_rd_data   (cache0_rd_data),
        .cache1_wr_data   (cache1_wr_data),
        .cache1_rd_data   (cache1_rd_data),
        .window_valid     (window_valid),
        .window_data      (window_data),
        .frame_done       (frame_done)
    );

    always #5 system_clk = ~system_clk;

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // ---------------- line cache model (write history, fixed delay) ----------------
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int            cache_depth = 3;

    always @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            cache0_rd_data <= '0;
            cache1_rd_data <= '0;
        end else if (cache_wr_en) begin
            q0.push_back(cache0_wr_data);
            q1.push_back(cache1_wr_data);
            while (q0.size() > cache_depth) void'(q0.pop_front());
            while (q1.size() > cache_depth) void'(q1.pop_front());
            cache0_rd_data <= (q0.size() == cache_depth) ? q0[0] : DW'($urandom);
            cache1_rd_data <= (q1.size() == cache_depth) ? q1[0] : DW'($urandom);
        end
    end

    // ---------------- reference frame and expected windows ----------------
    logic [FW-1:0] pix [0:7][0:2047];
    logic [WW-1:0] exp_q[$];
    int            win_cnt = 0;
    logic [WW-1:0] first_win = '0;
    logic [WW-1:0] last_win = '0;
    bit            prev_final = 1'b0;

    task automatic build_frame(input int rs, input int cs, input bit ramp);
        logic [WW-1:0] w;
        int y, x;
        for (int r = 0; r < cs; r++)
            for (int c = 0; c < 2 * rs; c++)
                pix[r][c] = ramp ? FW'(r * 2 * rs + c + 1) : FW'($urandom);
        exp_q.delete();
        for (int rc = 0; rc < cs; rc++) begin
            for (int kc = 0; kc < rs; kc++) begin
                w = '0;
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        y = rc - 1 + r;
                        x = 2 * kc - 1 + c;
                        if (y >= 0 && y < cs && x >= 0 && x < 2 * rs)
                            w[(r*4+c)*FW +: FW] = pix[y][x];
                    end
                end
                exp_q.push_back(w);
            end
        end
    endtask

    // ---------------- output monitor ----------------
    always @(negedge system_clk) begin
        bit fin;
        fin = 1'b0;
        if (rst_n) begin
            if (frame_done || prev_final)
                check_val("done_timing", WW'(frame_done), WW'(prev_final));
            if (window_valid) begin
                win_cnt++;
                if (win_cnt == 1) first_win = window_data;
                last_win = window_data;
                if (exp_q.size() == 0) begin
                    check_val("extra_window", WW'(window_valid), '0);
                end else begin
                    check_val("window", window_data, exp_q.pop_front());
                    fin = (exp_q.size() == 0);
                end
            end
        end
        prev_final = fin;
    end

    // ---------------- stimulus tasks (entered at a negedge) ----------------
    task automatic start_frame(input int rs, input int cs);
        cache_depth = rs;
        win_cnt     = 0;
        frame_start = 1'b1;
        row_size    = 10'(rs);
        col_size    = 10'(cs);
        @(negedge system_clk);
        frame_start = 1'b0;
        check_val("shift_size", WW'(cache_shift_size), WW'(rs - 2));
        check_val("ready_run", WW'(in_ready), WW'(1));
    endtask

    // stall_mode: 0 none, 1 one idle cycle before every word, 2 random idles
    task automatic feed_words(input int rs, input int cs, input int first, input int count,
                              input int stall_mode, input bit poke);
        int y, k;
        for (int w = first; w < first + count; w++) begin
            y = w / rs;
            k = w % rs;
            if (stall_mode == 1 || (stall_mode == 2 && $urandom_range(99) < 30)) begin
                in_valid = 1'b0;
                @(negedge system_clk);
                check_val("stall_quiet", WW'(window_valid), '0);
            end
            if (poke && w == rs) begin
                frame_start = 1'b1;
                row_size    = 10'd7;
                col_size    = 10'd5;
            end
            in_valid = 1'b1;
            in_data  = {pix[y][2*k+1], pix[y][2*k]};
            @(negedge system_clk);
            frame_start = 1'b0;
            row_size    = 10'(rs);
            col_size    = 10'(cs);
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic finish_frame(input int rs, input int cs, input bit poke);
        int n, ready_hits;
        n = 0;
        ready_hits = 0;
        while (cache_wr_en && n < 1100) begin
            if (in_ready) ready_hits++;
            if (poke && n == 0) begin
                frame_start = 1'b1;
                row_size    = 10'd9;
                col_size    = 10'd6;
            end
            n++;
            @(negedge system_clk);
            frame_start = 1'b0;
            row_size    = 10'(rs);
            col_size    = 10'(cs);
        end
        check_val("flush_len", WW'(n), WW'(rs + 1));
        check_val("flush_ready", WW'(ready_hits), '0);
        n = 0;
        while (!frame_done && n < 10) begin
            n++;
            @(negedge system_clk);
        end
        check_val("done_seen", WW'(frame_done), WW'(1));
        @(negedge system_clk);
        check_val("win_count", WW'(win_cnt), WW'(rs * cs));
        check_val("exp_left", WW'(exp_q.size()), '0);
        check_val("shift_keep", WW'(cache_shift_size), WW'(rs - 2));
        check_val("idle_ready", WW'(in_ready), '0);
    endtask

    task automatic run_frame(input int rs, input int cs, input bit ramp,
                             input int stall_mode, input bit poke);
        build_frame(rs, cs, ramp);
        start_frame(rs, cs);
        feed_words(rs, cs, 0, rs * cs, stall_mode, poke);
        finish_frame(rs, cs, poke);
    endtask

    localparam logic [WW-1:0] RAMP_W00 = 96'h09080700_03020100_00000000;
    localparam logic [WW-1:0] RAMP_W22 = 96'h00000000_00121110_000c0b0a;

    initial begin
        repeat (3) @(negedge system_clk);
        check_val("rst_ready", WW'(in_ready), '0);
        check_val("rst_wvalid", WW'(window_valid), '0);
        check_val("rst_wdata", window_data, '0);
        check_val("rst_done", WW'(frame_done), '0);
        check_val("rst_wr_en", WW'(cache_wr_en), '0);
        check_val("rst_shift", WW'(cache_shift_size), '0);
        rst_n = 1'b1;
        @(negedge system_clk);

        // ramp 3x3, no stalls
        run_frame(3, 3, 1'b1, 0, 1'b0);
        check_val("ramp_w00", first_win, RAMP_W00);
        check_val("ramp_w22", last_win, RAMP_W22);

        // same frame with in_valid toggling, started right after frame_done
        run_frame(3, 3, 1'b1, 1, 1'b0);
        check_val("toggle_w00", first_win, RAMP_W00);
        check_val("toggle_w22", last_win, RAMP_W22);

        // back-to-back random frames with random gaps
        run_frame(5, 4, 1'b0, 2, 1'b0);
        run_frame(6, 3, 1'b0, 0, 1'b0);

        // frame_start pulses during RUN and FLUSH must be ignored
        run_frame(3, 3, 1'b1, 0, 1'b1);

        // asynchronous reset in the middle of a frame
        build_frame(3, 3, 1'b1);
        start_frame(3, 3);
        feed_words(3, 3, 0, 6, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_val("mid_rst_wvalid", WW'(window_valid), '0);
        check_val("mid_rst_wdata", window_data, '0);
        check_val("mid_rst_done", WW'(frame_done), '0);
        check_val("mid_rst_ready", WW'(in_ready), '0);
        check_val("mid_rst_wr_en", WW'(cache_wr_en), '0);
        @(negedge system_clk);
        rst_n = 1'b1;
        repeat (5) @(negedge system_clk);
        run_frame(4, 2, 1'b0, 2, 1'b0);

        // widest row
        run_frame(1023, 2, 1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
